// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU selector codes and sequencer state encoding
// shared by the accumulator sequencer blocks.
package alu_pkg;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_XOR = 4'h2;
    localparam logic [3:0] OP_SHL = 4'h3;
    localparam logic [3:0] OP_CMA = 4'h6;
    localparam logic [3:0] OP_LDA = 4'h8;
    localparam logic [3:0] OP_STA = 4'h9;
    localparam logic [3:0] OP_CLA = 4'hA;
    localparam logic [3:0] OP_CLE = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;
    localparam logic [2:0] SEL_ADD  = 3'b000;
    localparam logic [2:0] SEL_SUB  = 3'b001;
    localparam logic [2:0] SEL_XOR  = 3'b010;
    localparam logic [2:0] SEL_SHL  = 3'b011;
    localparam logic [2:0] SEL_CMA  = 3'b110;
    localparam logic [2:0] SEL_NONE = 3'b111;
    typedef enum logic [2:0] {ST_IDLE, ST_READ, ST_LOAD, ST_EXEC, ST_STORE, ST_HALT} state_t;
    // SEL_NONE doubles as "this op does not write AC from the ALU"
    function automatic logic [2:0] sel_of(input logic [3:0] op);
        return op == OP_ADD ? SEL_ADD :
               op == OP_SUB ? SEL_SUB :
               op == OP_XOR ? SEL_XOR :
               op == OP_SHL ? SEL_SHL :
               op == OP_CMA ? SEL_CMA : SEL_NONE;
    endfunction
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: instruction handshake, memory bus, ALU operand bus and status.
interface alu_sequencer_if #(parameter int DATA_W = 8, parameter int ADDR_W = 8);
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        instr_op;
    logic [ADDR_W-1:0] instr_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [2:0]        alu_sel;
    logic [DATA_W-1:0] alu_ac;
    logic [DATA_W-1:0] alu_dr;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] ac_out;
    logic              e_out;
    logic              done;
    logic              halted;
    modport slave (
        input  instr_valid, instr_op, instr_addr, mem_rdata, alu_result,
        output instr_ready, mem_rd, mem_wr, mem_addr, mem_wdata, alu_sel, alu_ac, alu_dr,
               ac_out, e_out, done, halted
    );
    modport master (
        output instr_valid, instr_op, instr_addr, mem_rdata, alu_result,
        input  instr_ready, mem_rd, mem_wr, mem_addr, mem_wdata, alu_sel, alu_ac, alu_dr,
               ac_out, e_out, done, halted
    );
endinterface

// File: rtl/alu_e_flag_unit.sv
// alu_e_flag_unit: next value of the E (carry/link) flag for the op executing in EXEC.
module alu_e_flag_unit import alu_pkg::*; #(parameter int DATA_W = 8) (
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] ac_i,
    input  logic [DATA_W-1:0] dr_i,
    input  logic              e_i,
    output logic              e_o
);
    logic [DATA_W:0] sum;
    assign sum = {1'b0, ac_i} + {1'b0, dr_i};
    assign e_o = op_i == OP_ADD ? sum[DATA_W] :
                 op_i == OP_SUB ? ac_i >= dr_i :
                 op_i == OP_SHL ? ac_i[DATA_W-1] :
                 op_i == OP_CLE ? 1'b0 : e_i;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control for the 8-bit accumulator datapath; owns AC, DR and E,
// sequences memory reads/writes and drives the external combinational ALU.
module alu_sequencer import alu_pkg::*; #(parameter int DATA_W = 8, parameter int ADDR_W = 8) (
    input logic          clk,
    input logic          rst_n,
    alu_sequencer_if.slave bus
);
    state_t            state_q;
    logic [3:0]        op_q;
    logic [DATA_W-1:0] ac_q, dr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        sel_q;
    logic              e_q, e_d, done_q, rd_q, wr_q, halted_q;

    alu_e_flag_unit #(.DATA_W(DATA_W)) u_e_flag (
        .op_i(op_q), .ac_i(ac_q), .dr_i(dr_q), .e_i(e_q), .e_o(e_d)
    );

    assign bus.instr_ready = state_q == ST_IDLE;
    assign bus.mem_rd      = rd_q;
    assign bus.mem_wr      = wr_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = ac_q;
    assign bus.alu_sel     = sel_q;
    assign bus.alu_ac      = ac_q;
    assign bus.alu_dr      = dr_q;
    assign bus.ac_out      = ac_q;
    assign bus.e_out       = e_q;
    assign bus.done        = done_q;
    assign bus.halted      = halted_q;

    // Strobes, done and alu_sel default low/none so each is a single-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            ac_q     <= '0;
            dr_q     <= '0;
            addr_q   <= '0;
            sel_q    <= SEL_NONE;
            e_q      <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            sel_q  <= SEL_NONE;
            case (state_q)
                ST_IDLE: if (bus.instr_valid) begin
                    op_q <= bus.instr_op;
                    if (bus.instr_op inside {OP_ADD, OP_SUB, OP_XOR, OP_LDA}) begin
                        state_q <= ST_READ;
                        rd_q    <= 1'b1;
                        addr_q  <= bus.instr_addr;
                    end else if (bus.instr_op == OP_STA) begin
                        state_q <= ST_STORE;
                        wr_q    <= 1'b1;
                        addr_q  <= bus.instr_addr;
                    end else if (bus.instr_op == OP_HLT) begin
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                        done_q   <= 1'b1;
                    end else begin
                        state_q <= ST_EXEC;
                        sel_q   <= sel_of(bus.instr_op);
                        if (bus.instr_op == OP_CLA) ac_q <= '0;
                        if (bus.instr_op == OP_CLE) e_q <= 1'b0;
                    end
                end
                ST_READ: state_q <= ST_LOAD;
                ST_LOAD: if (op_q == OP_LDA) begin
                    ac_q    <= bus.mem_rdata;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end else begin
                    dr_q    <= bus.mem_rdata;
                    sel_q   <= sel_of(op_q);
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (sel_q != SEL_NONE) ac_q <= bus.alu_result;
                    e_q     <= e_d;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_STORE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table, multi-cycle corner sequences and a random run
// checked against an instruction-level model of the accumulator machine.
module tb_alu_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic pre_en;
    logic [7:0] pre_a, pre_d;
    logic [7:0] mem [256];
    int n_cmp = 0, n_err = 0, rd_cnt = 0, wr_cnt = 0;

    alu_sequencer_if #(.DATA_W(8), .ADDR_W(8)) bus();
    alu_sequencer #(.DATA_W(8), .ADDR_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    initial forever #5 clk = ~clk;

    // Reference ALU and synchronous memory (pre_en lets the bench seed operand data)
    always_comb begin
        bus.alu_result = 8'h00;
        case (bus.alu_sel)
            3'b000:  bus.alu_result = bus.alu_ac + bus.alu_dr;
            3'b001:  bus.alu_result = bus.alu_ac - bus.alu_dr;
            3'b010:  bus.alu_result = bus.alu_ac ^ bus.alu_dr;
            3'b011:  bus.alu_result = bus.alu_ac << 1;
            3'b110:  bus.alu_result = ~bus.alu_ac;
            default: bus.alu_result = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        if (pre_en) mem[pre_a] <= pre_d;
        if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_rd) rd_cnt <= rd_cnt + 1;
        if (bus.mem_wr) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) check("rd_wr_exclusive", 32'(bus.mem_rd & bus.mem_wr), 32'd0);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_reset(input string tag);
        check({tag, "_ac"}, 32'(bus.ac_out), 32'h00);
        check({tag, "_e"}, 32'(bus.e_out), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_rd"}, 32'(bus.mem_rd), 32'd0);
        check({tag, "_wr"}, 32'(bus.mem_wr), 32'd0);
        check({tag, "_halted"}, 32'(bus.halted), 32'd0);
        check({tag, "_addr"}, 32'(bus.mem_addr), 32'h00);
        check({tag, "_sel"}, 32'(bus.alu_sel), 32'h7);
        check({tag, "_ready"}, 32'(bus.instr_ready), 32'd1);
    endtask

    // Offers one instruction, returns cycles from accept edge to done and strobe counts
    task automatic run(input logic [3:0] op, input logic [7:0] a, input logic [7:0] d,
                       output int lat, output int rd, output int wr);
        int n, r0, w0;
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_addr  = a;
        pre_en = 1'b1;
        pre_a  = a;
        pre_d  = d;
        n = 0;
        while (!bus.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(bus.instr_ready), 32'd1);
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        pre_en = 1'b0;
        lat = 1;
        while (!bus.done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = rd_cnt - r0;
        wr = wr_cnt - w0;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, d, ac;
        logic       e;
        int         lat, rd, wr;
    } vec_t;

    initial begin
        vec_t vecs[19];
        int lat, rd, wr, r0, w0, dn, rdy, hl, exp_lat;
        logic [3:0] op;
        logic [7:0] a, d, m_ac;
        logic [8:0] s;
        logic m_e, rdop;
        vecs[0]  = '{4'h8, 8'h10, 8'hF0, 8'hF0, 1'b0, 3, 1, 0};
        vecs[1]  = '{4'h0, 8'h11, 8'h20, 8'h10, 1'b1, 4, 1, 0};
        vecs[2]  = '{4'h8, 8'h12, 8'h05, 8'h05, 1'b1, 3, 1, 0};
        vecs[3]  = '{4'h1, 8'h13, 8'h07, 8'hFE, 1'b0, 4, 1, 0};
        vecs[4]  = '{4'h8, 8'h13, 8'h07, 8'h07, 1'b0, 3, 1, 0};
        vecs[5]  = '{4'h1, 8'h14, 8'h07, 8'h00, 1'b1, 4, 1, 0};
        vecs[6]  = '{4'h8, 8'h15, 8'h81, 8'h81, 1'b1, 3, 1, 0};
        vecs[7]  = '{4'h3, 8'h00, 8'h00, 8'h02, 1'b1, 2, 0, 0};
        vecs[8]  = '{4'h6, 8'h00, 8'h00, 8'hFD, 1'b1, 2, 0, 0};
        vecs[9]  = '{4'hB, 8'h00, 8'h00, 8'hFD, 1'b0, 2, 0, 0};
        vecs[10] = '{4'h2, 8'h16, 8'h0F, 8'hF2, 1'b0, 4, 1, 0};
        vecs[11] = '{4'h9, 8'h17, 8'h00, 8'hF2, 1'b0, 2, 0, 1};
        vecs[12] = '{4'h0, 8'h18, 8'h0E, 8'h00, 1'b1, 4, 1, 0};
        vecs[13] = '{4'hA, 8'h00, 8'h00, 8'h00, 1'b1, 2, 0, 0};
        vecs[14] = '{4'h5, 8'h00, 8'h00, 8'h00, 1'b1, 2, 0, 0};
        vecs[15] = '{4'hC, 8'h00, 8'h00, 8'h00, 1'b1, 2, 0, 0};
        vecs[16] = '{4'h3, 8'h00, 8'h00, 8'h00, 1'b0, 2, 0, 0};
        vecs[17] = '{4'h6, 8'h00, 8'h00, 8'hFF, 1'b0, 2, 0, 0};
        vecs[18] = '{4'h0, 8'h19, 8'h01, 8'h00, 1'b1, 4, 1, 0};

        rst_n = 1'b0;
        pre_en = 1'b0;
        pre_a = '0;
        pre_d = '0;
        bus.instr_valid = 1'b0;
        bus.instr_op = '0;
        bus.instr_addr = '0;
        #12;
        check_reset("por");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            run(vecs[i].op, vecs[i].a, vecs[i].d, lat, rd, wr);
            check($sformatf("vec%0d_ac", i), 32'(bus.ac_out), 32'(vecs[i].ac));
            check($sformatf("vec%0d_e", i), 32'(bus.e_out), 32'(vecs[i].e));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
            check($sformatf("vec%0d_wr", i), 32'(wr), 32'(vecs[i].wr));
            if (vecs[i].op == 4'h9) check($sformatf("vec%0d_mem", i), 32'(mem[vecs[i].a]), 32'(vecs[i].ac));
        end

        // Back-to-back: valid held high across STA 0x20, CLA, STA 0x21
        run(4'h8, 8'h30, 8'h5A, lat, rd, wr);
        check("b2b_lda_ac", 32'(bus.ac_out), 32'h5A);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op = 4'h9;
        bus.instr_addr = 8'h20;
        @(posedge clk); #1;
        check("b2b_sta1_busy", 32'(bus.instr_ready), 32'd0);
        check("b2b_sta1_wr", 32'(bus.mem_wr), 32'd1);
        check("b2b_sta1_addr", 32'(bus.mem_addr), 32'h20);
        check("b2b_sta1_data", 32'(bus.mem_wdata), 32'h5A);
        bus.instr_op = 4'hA;
        @(posedge clk); #1;
        check("b2b_sta1_done", 32'(bus.done), 32'd1);
        check("b2b_sta1_ready", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        check("b2b_cla_busy", 32'(bus.instr_ready), 32'd0);
        check("b2b_cla_nodone", 32'(bus.done), 32'd0);
        bus.instr_op = 4'h9;
        bus.instr_addr = 8'h21;
        @(posedge clk); #1;
        check("b2b_cla_done", 32'(bus.done), 32'd1);
        check("b2b_cla_ac", 32'(bus.ac_out), 32'h00);
        check("b2b_cla_ready", 32'(bus.instr_ready), 32'd1);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        check("b2b_sta2_wr", 32'(bus.mem_wr), 32'd1);
        check("b2b_sta2_addr", 32'(bus.mem_addr), 32'h21);
        check("b2b_sta2_data", 32'(bus.mem_wdata), 32'h00);
        @(posedge clk); #1;
        check("b2b_sta2_done", 32'(bus.done), 32'd1);
        check("b2b_mem20", 32'(mem[8'h20]), 32'h5A);
        check("b2b_mem21", 32'(mem[8'h21]), 32'h00);

        // Reset asserted while a read is in flight
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op = 4'h0;
        bus.instr_addr = 8'h40;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        check("rst_in_read", 32'(bus.mem_rd), 32'd1);
        r0 = rd_cnt;
        w0 = wr_cnt;
        rst_n = 1'b0;
        #1;
        check_reset("midrd");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrd_no_wr", 32'(wr_cnt - w0), 32'd0);
        check("midrd_no_rd", 32'(rd_cnt - r0), 32'd0);
        check("midrd_ready", 32'(bus.instr_ready), 32'd1);

        // Random instruction stream against an instruction-level model
        m_ac = 8'h00;
        m_e = 1'b0;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 14));
            a = 8'($urandom);
            d = 8'($urandom);
            rdop = op inside {4'h0, 4'h1, 4'h2, 4'h8};
            case (op)
                4'h0: begin s = m_ac + d; m_ac = s[7:0]; m_e = s[8]; end
                4'h1: begin m_e = m_ac >= d; m_ac = m_ac - d; end
                4'h2: m_ac = m_ac ^ d;
                4'h3: begin m_e = m_ac[7]; m_ac = {m_ac[6:0], 1'b0}; end
                4'h6: m_ac = ~m_ac;
                4'h8: m_ac = d;
                4'hA: m_ac = 8'h00;
                4'hB: m_e = 1'b0;
                default: ;
            endcase
            exp_lat = !rdop ? 2 : op == 4'h8 ? 3 : 4;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run(op, a, d, lat, rd, wr);
            check($sformatf("rnd%0d_op%0h_ac", i, op), 32'(bus.ac_out), 32'(m_ac));
            check($sformatf("rnd%0d_op%0h_e", i, op), 32'(bus.e_out), 32'(m_e));
            check($sformatf("rnd%0d_op%0h_lat", i, op), 32'(lat), 32'(exp_lat));
            check($sformatf("rnd%0d_op%0h_rd", i, op), 32'(rd), 32'(rdop));
            check($sformatf("rnd%0d_op%0h_wr", i, op), 32'(wr), 32'(op == 4'h9));
            if (op == 4'h9) check($sformatf("rnd%0d_sta_mem", i), 32'(mem[a]), 32'(m_ac));
        end

        // HLT, then an ADD held valid must never be taken
        run(4'hF, 8'h00, 8'h00, lat, rd, wr);
        check("hlt_lat", 32'(lat), 32'd1);
        check("hlt_halted", 32'(bus.halted), 32'd1);
        check("hlt_ready", 32'(bus.instr_ready), 32'd0);
        @(negedge clk);
        bus.instr_valid = 1'b1;
        bus.instr_op = 4'h0;
        bus.instr_addr = 8'h50;
        r0 = rd_cnt;
        dn = 0;
        rdy = 0;
        hl = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            dn += int'(bus.done);
            rdy += int'(bus.instr_ready);
            hl += int'(bus.halted);
        end
        check("hlt_no_done", 32'(dn), 32'd0);
        check("hlt_no_ready", 32'(rdy), 32'd0);
        check("hlt_stays", 32'(hl), 32'd10);
        check("hlt_no_rd", 32'(rd_cnt - r0), 32'd0);
        bus.instr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset("hltrst");
        @(negedge clk);
        rst_n = 1'b1;
        run(4'h0, 8'h50, 8'h33, lat, rd, wr);
        check("post_rst_add_ac", 32'(bus.ac_out), 32'h33);
        check("post_rst_add_e", 32'(bus.e_out), 32'd0);
        check("post_rst_add_lat", 32'(lat), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
